sign_ext_window_accumulator: RTL and testbench

Downstream consumer of the 8-bit to 32-bit sign-extension stage. The block takes a stream of signed 8-bit samples over a valid/ready handshake and sign-extends each one to 32 bits internally. It accumulates WINDOW samples, then presents the 32-bit two's-complement sum, with the count of samples it contains, on a registered valid/ready output. A flush input closes a window early and emits the partial sum.

---
 rtl/sign_ext_window_accumulator.sv | 141 ++++++++++++++
 tb/tb_sign_ext_window_accumulator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sign_ext_window_accumulator.sv
// ---------------------------------------------------------------------------
// sign_ext_window_accumulator
//
// Purpose:
//   Accepts signed 8-bit samples over a valid/ready handshake, sign-extends
//   each one to 32 bits, and sums WINDOW samples into a 32-bit two's-complement
//   result. The result is presented with its sample count on a registered
//   valid/ready output. A flush closes the open window early and emits the
//   partial sum. An empty window is never emitted.
//
// Ports:
//   clk        in   1   rising-edge clock
//   areset     in   1   asynchronous active-high reset
//   in         in   8   signed sample
//   in_valid   in   1   sample on `in` is valid
//   in_ready   out  1   sample can be accepted (= !out_valid || out_ready)
//   flush      in   1   close the open window at this edge
//   out        out  32  registered window sum
//   out_cnt    out  8   number of samples summed into `out`
//   out_valid  out  1   `out` / `out_cnt` are valid
//   out_ready  in   1   downstream accepts the result
// ---------------------------------------------------------------------------
module sign_ext_window_accumulator #(
    parameter int unsigned WINDOW = 4
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [7:0]  in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [31:0] out,
    output logic [7:0]  out_cnt,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [7:0] WIN8 = 8'(WINDOW);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    function automatic logic [31:0] sext8(input logic [7:0] val);
        sext8 = {{24{val[7]}}, val};
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_acc;
    logic [7:0]  r_cnt;

    logic        w_accept;
    logic [31:0] w_ext;
    logic [31:0] w_sum_next;
    logic [7:0]  w_cnt_next;
    logic        w_close;

    // out_valid is the FULL state itself, so it is a pure register output.
    assign out_valid = (r_state == ST_FULL);

    // Ready depends only on the output register and downstream ready.
    assign in_ready  = !out_valid || out_ready;

    // Datapath next values, window-close decision and next-state logic.
    always_comb begin
        w_accept     = in_valid && in_ready;
        w_ext        = sext8(in);
        w_sum_next   = r_acc + (w_accept ? w_ext : 32'd0);
        w_cnt_next   = r_cnt + {7'd0, w_accept};
        // Flush counts only when something would be emitted; no empty results.
        w_close      = in_ready &&
                       ((w_accept && (w_cnt_next == WIN8)) ||
                        (flush && (w_cnt_next != 8'd0)));
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: begin
                if (w_close) begin
                    w_state_next = ST_FULL;
                end else begin
                    w_state_next = ST_ACCUM;
                end
            end
            ST_FULL: begin
                // A close while draining reloads the output and stays FULL.
                if (w_close) begin
                    w_state_next = ST_FULL;
                end else if (out_ready) begin
                    w_state_next = ST_ACCUM;
                end else begin
                    w_state_next = ST_FULL;
                end
            end
            default: begin
                w_state_next = ST_ACCUM;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Accumulator and open-window sample count.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_acc <= 32'd0;
            r_cnt <= 8'd0;
        end else if (w_close) begin
            r_acc <= 32'd0;
            r_cnt <= 8'd0;
        end else if (w_accept) begin
            r_acc <= w_sum_next;
            r_cnt <= w_cnt_next;
        end else begin
            r_acc <= r_acc;
            r_cnt <= r_cnt;
        end
    end

    // Output result registers, loaded only when a window closes.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            out     <= 32'd0;
            out_cnt <= 8'd0;
        end else if (w_close) begin
            out     <= w_sum_next;
            out_cnt <= w_cnt_next;
        end else begin
            out     <= out;
            out_cnt <= out_cnt;
        end
    end

endmodule

// File: tb/tb_sign_ext_window_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sign_ext_window_accumulator
//
// Directed self-checking bench for sign_ext_window_accumulator (WINDOW=4).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_sign_ext_window_accumulator;

    logic        clk;
    logic        areset;
    logic [7:0]  in;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] out;
    logic [7:0]  out_cnt;
    logic        out_valid;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    sign_ext_window_accumulator #(.WINDOW(4)) dut (
        .clk       (clk),
        .areset    (areset),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out       (out),
        .out_cnt   (out_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock once, settle just after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
        in_valid  = v;
        in        = d;
        flush     = f;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  stream_d [12];
    logic [31:0] stream_e [3];

    initial begin
        stream_d = '{8'h3C, 8'hA5, 8'h7E, 8'h81,
                     8'h00, 8'hFF, 8'h12, 8'hF0,
                     8'h40, 8'h40, 8'hC0, 8'h99};
        // -32, +1, -39 computed by hand
        stream_e = '{32'hFFFFFFE0, 32'h00000001, 32'hFFFFFFD9};

        areset    = 1'b1;
        in        = 8'h00;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_out",       out,       32'h0);
        chk("reset_out_cnt",   out_cnt,   32'h0);
        chk("reset_out_valid", out_valid, 32'h0);
        chk("reset_in_ready",  in_ready,  32'h1);
        areset = 1'b0;

        // Mixed signs: 1 - 1 - 128 + 127 = -1
        step(1'b1, 8'h01, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 1'b0, 1'b1);
        step(1'b1, 8'h80, 1'b0, 1'b1);
        chk("mixed_not_yet", out_valid, 32'h0);
        step(1'b1, 8'h7F, 1'b0, 1'b1);
        chk("mixed_valid", out_valid, 32'h1);
        chk("mixed_out",   out,       32'hFFFFFFFF);
        chk("mixed_cnt",   out_cnt,   32'd4);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("mixed_drain", out_valid, 32'h0);

        // Negative extreme then positive extreme, back to back
        for (int i = 0; i < 4; i++) step(1'b1, 8'h80, 1'b0, 1'b1);
        chk("neg_valid", out_valid, 32'h1);
        chk("neg_out",   out,       32'hFFFFFE00);
        chk("neg_cnt",   out_cnt,   32'd4);
        step(1'b1, 8'h7F, 1'b0, 1'b1);
        chk("pos_first_drains", out_valid, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h7F, 1'b0, 1'b1);
        chk("pos_valid", out_valid, 32'h1);
        chk("pos_out",   out,       32'h000001FC);
        chk("pos_cnt",   out_cnt,   32'd4);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure: 1+2+3+4 = 10 with out_ready low
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        step(1'b1, 8'h04, 1'b0, 1'b0);
        chk("bp_valid", out_valid, 32'h1);
        chk("bp_out",   out,       32'd10);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready_low", in_ready, 32'h0);
            step(1'b1, 8'h11, 1'b1, 1'b0);
            chk("bp_hold_out", out,       32'd10);
            chk("bp_hold_cnt", out_cnt,   32'd4);
            chk("bp_hold_vld", out_valid, 32'h1);
        end
        in_valid  = 1'b1;
        in        = 8'h11;
        flush     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_comb", in_ready, 32'h1);
        @(posedge clk);
        #1;
        chk("bp_drained", out_valid, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h11, 1'b0, 1'b1);
        chk("bp_next_valid", out_valid, 32'h1);
        chk("bp_next_out",   out,       32'h00000044);
        chk("bp_next_cnt",   out_cnt,   32'd4);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Flush alone: 5 + (-2) = 3
        step(1'b1, 8'h05, 1'b0, 1'b1);
        step(1'b1, 8'hFE, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("flush_valid", out_valid, 32'h1);
        chk("flush_out",   out,       32'h00000003);
        chk("flush_cnt",   out_cnt,   32'd2);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("flush_drain", out_valid, 32'h0);
        // Flush with nothing pending produces nothing
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("flush_empty_valid", out_valid, 32'h0);
        chk("flush_empty_out",   out,       32'h00000003);
        // Flush together with a third sample: 5 - 2 + 16 = 19
        step(1'b1, 8'h05, 1'b0, 1'b1);
        step(1'b1, 8'hFE, 1'b0, 1'b1);
        step(1'b1, 8'h10, 1'b1, 1'b1);
        chk("flush_acc_valid", out_valid, 32'h1);
        chk("flush_acc_out",   out,       32'h00000013);
        chk("flush_acc_cnt",   out_cnt,   32'd3);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Streaming: 12 samples back to back
        for (int i = 0; i < 12; i++) begin
            step(1'b1, stream_d[i], 1'b0, 1'b1);
            chk("stream_in_ready", in_ready, 32'h1);
            chk("stream_valid", out_valid, ((i % 4) == 3) ? 32'h1 : 32'h0);
            if ((i % 4) == 3) begin
                chk("stream_out", out,     stream_e[i / 4]);
                chk("stream_cnt", out_cnt, 32'd4);
            end
        end

        // Async reset mid-window, between edges
        step(1'b1, 8'h33, 1'b0, 1'b1);
        step(1'b1, 8'h44, 1'b0, 1'b1);
        in_valid = 1'b0;
        #2;
        areset = 1'b1;
        #1;
        chk("areset_out",       out,       32'h0);
        chk("areset_out_cnt",   out_cnt,   32'h0);
        chk("areset_out_valid", out_valid, 32'h0);
        chk("areset_in_ready",  in_ready,  32'h1);
        areset = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 8'h02, 1'b0, 1'b1);
        chk("post_reset_valid", out_valid, 32'h1);
        chk("post_reset_out",   out,       32'h00000008);
        chk("post_reset_cnt",   out_cnt,   32'd4);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("post_reset_drain", out_valid, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
